i3c_target_hdr_ddr_rx: RTL and testbench

Target-side HDR-DDR word receiver: the far end of the controller's SDR→HDR path that issues ENTHDR and then drives HDR-DDR frames. Once the target's CCC logic has decoded ENTHDR0 and raised `i_hdr_en`, this block samples SDA on both SCL edges and assembles 20-bit frames (2-bit preamble, 16-bit payload, 2 parity bits). It checks preamble and parity and detects the HDR Exit and HDR Restart patterns, handing decoded words to the target's HDR command/data handler.

---
 rtl/i3c_target_hdr_ddr_rx.sv | 164 ++++++++++++++++
 tb/tb_i3c_target_hdr_ddr_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/i3c_target_hdr_ddr_rx.sv
// rtl/i3c_target_hdr_ddr_rx.sv - HDR-DDR target word receiver with Exit/Restart detection
// Optional input synchronizer: define I3C_HDR_RX_SYNC_EN.
module i3c_target_hdr_ddr_rx #(
  parameter int EXIT_FALL_CNT    = 4,
  parameter int RESTART_FALL_CNT = 2
) (
  input  logic        i_sdr_clk,
  input  logic        i_sdr_rst,
  input  logic        i_hdr_en,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic [15:0] o_hdr_word,
  output logic        o_hdr_word_valid,
  output logic        o_hdr_word_is_cmd,
  output logic        o_hdr_parity_err,
  output logic        o_hdr_preamble_err,
  output logic        o_hdr_exit,
  output logic        o_hdr_restart,
  output logic        o_hdr_active
);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_DIS} state_t;

  localparam logic [2:0] EXIT_CNT    = 3'(EXIT_FALL_CNT);
  localparam logic [2:0] RESTART_CNT = 3'(RESTART_FALL_CNT);

  state_t      state, state_n;
  logic        scl_d, sda_d;
  logic        scl_q, scl_qq, sda_q, sda_qq;
  logic [2:0]  fall_cnt, fall_inc;
  logic [4:0]  bit_cnt;
  logic [19:0] shift_q;
  logic        done_q, exit_q, restart_q;
  logic        scl_rise, scl_edge, sda_fall, exit_hit, restart_hit;
  logic        do_shift, do_done, do_exit, do_restart, do_clr;
  logic [15:0] payload;
  logic [1:0]  parity_exp;

`ifdef I3C_HDR_RX_SYNC_EN
  logic [1:0] scl_sync, sda_sync;

  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) begin
      scl_sync <= 2'b00;
      sda_sync <= 2'b00;
    end else begin
      scl_sync <= {scl_sync[0], i_scl};
      sda_sync <= {sda_sync[0], i_sda};
    end
  end

  assign scl_d = scl_sync[1];
  assign sda_d = sda_sync[1];
`else
  assign scl_d = i_scl;
  assign sda_d = i_sda;
`endif

  // Edges are seen between the edge register and its previous value.
  assign scl_rise = scl_q & ~scl_qq;
  assign scl_edge = scl_q ^ scl_qq;
  assign sda_fall = ~sda_q & sda_qq & ~scl_q;
  assign fall_inc = (fall_cnt == 3'd7) ? 3'd7 : fall_cnt + 3'd1;
  assign exit_hit = sda_fall && (fall_inc >= EXIT_CNT);
  assign restart_hit = scl_rise && (fall_cnt >= RESTART_CNT) && (fall_cnt < EXIT_CNT);

  assign payload    = shift_q[17:2];
  assign parity_exp = {^(payload & 16'hAAAA), ~^(payload & 16'h5555)};
  assign o_hdr_active = (state == ACTIVE);

  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n    = state;
    do_shift   = 1'b0;
    do_done    = 1'b0;
    do_exit    = 1'b0;
    do_restart = 1'b0;
    do_clr     = 1'b0;
    case (state)
      IDLE: begin
        do_clr = 1'b1;
        if (i_hdr_en) state_n = ACTIVE;
      end
      ACTIVE: begin
        // Exit beats Restart, and Restart beats the 20th bit.
        if (exit_hit) begin
          do_exit = 1'b1;
          do_clr  = 1'b1;
          state_n = WAIT_DIS;
        end else if (restart_hit) begin
          do_restart = 1'b1;
          do_clr     = 1'b1;
        end else if (scl_edge) begin
          do_shift = 1'b1;
          do_done  = (bit_cnt == 5'd19);
        end
      end
      WAIT_DIS: do_clr = 1'b1;
      default: state_n = IDLE;
    endcase
    if (!i_hdr_en) begin
      state_n    = IDLE;
      do_done    = 1'b0;
      do_exit    = 1'b0;
      do_restart = 1'b0;
      do_clr     = 1'b1;
    end
  end

  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) begin
      scl_q              <= 1'b0;
      scl_qq             <= 1'b0;
      sda_q              <= 1'b0;
      sda_qq             <= 1'b0;
      fall_cnt           <= 3'd0;
      bit_cnt            <= 5'd0;
      shift_q            <= 20'd0;
      done_q             <= 1'b0;
      exit_q             <= 1'b0;
      restart_q          <= 1'b0;
      o_hdr_word         <= 16'h0000;
      o_hdr_word_valid   <= 1'b0;
      o_hdr_word_is_cmd  <= 1'b0;
      o_hdr_parity_err   <= 1'b0;
      o_hdr_preamble_err <= 1'b0;
      o_hdr_exit         <= 1'b0;
      o_hdr_restart      <= 1'b0;
    end else begin
      scl_q  <= scl_d;
      scl_qq <= scl_q;
      sda_q  <= sda_d;
      sda_qq <= sda_q;

      if (do_clr || scl_edge) fall_cnt <= 3'd0;
      else if (sda_fall)      fall_cnt <= fall_inc;

      if (do_clr)        bit_cnt <= 5'd0;
      else if (do_shift) bit_cnt <= (bit_cnt == 5'd19) ? 5'd0 : bit_cnt + 5'd1;

      if (do_shift) shift_q <= {shift_q[18:0], sda_q};

      done_q    <= do_done;
      exit_q    <= do_exit;
      restart_q <= do_restart;

      // Second stage decodes the frame captured one cycle earlier.
      o_hdr_word_valid <= done_q && i_hdr_en && (state == ACTIVE);
      if (done_q && i_hdr_en && (state == ACTIVE)) begin
        o_hdr_word         <= payload;
        o_hdr_word_is_cmd  <= (shift_q[19:18] == 2'b01);
        o_hdr_preamble_err <= (shift_q[19:18] == 2'b00);
        o_hdr_parity_err   <= (shift_q[1:0] != parity_exp);
      end
      o_hdr_exit    <= exit_q && i_hdr_en;
      o_hdr_restart <= restart_q && i_hdr_en;
    end
  end

endmodule

// File: tb/tb_i3c_target_hdr_ddr_rx.sv
// tb/tb_i3c_target_hdr_ddr_rx.sv - directed and random frame checks against a behavioural model
module tb_i3c_target_hdr_ddr_rx;

`ifdef I3C_HDR_RX_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_en = 1'b0;
  logic        scl = 1'b0;
  logic        sda = 1'b1;
  logic [15:0] word;
  logic        valid, is_cmd, par_err, pre_err, hexit, hrestart, active;

  int tests = 0;
  int fails = 0;
  int valid_seen = 0;
  int exit_seen = 0;
  int restart_seen = 0;

  always #5 clk = ~clk;

  i3c_target_hdr_ddr_rx #(.EXIT_FALL_CNT(4), .RESTART_FALL_CNT(2)) dut (
    .i_sdr_clk(clk), .i_sdr_rst(rst), .i_hdr_en(hdr_en), .i_scl(scl), .i_sda(sda),
    .o_hdr_word(word), .o_hdr_word_valid(valid), .o_hdr_word_is_cmd(is_cmd),
    .o_hdr_parity_err(par_err), .o_hdr_preamble_err(pre_err), .o_hdr_exit(hexit),
    .o_hdr_restart(hrestart), .o_hdr_active(active)
  );

  always @(negedge clk) begin
    if (valid)    valid_seen++;
    if (hexit)    exit_seen++;
    if (hrestart) restart_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parity from the bit-counting rule: PA1 odd-parity of odd bits, PA0 inverted parity of even bits.
  function automatic logic [1:0] ref_par(input logic [15:0] w);
    int odd_ones = 0;
    int even_ones = 0;
    for (int i = 0; i < 16; i++)
      if (w[i]) begin
        if (i % 2 == 1) odd_ones++;
        else            even_ones++;
      end
    return {1'(odd_ones % 2 == 1), 1'(even_ones % 2 == 0)};
  endfunction

  task automatic drive_bits(input logic [19:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(negedge clk);
      sda = f[19-i];
      repeat (3) @(negedge clk);
      scl = ~scl;
    end
  endtask

  task automatic sda_falls(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(negedge clk);
      sda = 1'b1;
      repeat (3) @(negedge clk);
      sda = 1'b0;
    end
  endtask

  task automatic send_frame(input string tag, input logic [1:0] pre, input logic [15:0] pl,
                            input logic [1:0] par);
    int first;
    int v0;
    logic [15:0] w_c;
    logic c_c, pe_c, pre_c;
    first = -1;
    w_c = '0; c_c = 0; pe_c = 0; pre_c = 0;
    drive_bits({pre, pl, par}, 19);
    v0 = valid_seen;
    drive_bits({pre, pl, par} << 19, 1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid && first < 0) begin
        first = k; w_c = word; c_c = is_cmd; pe_c = par_err; pre_c = pre_err;
      end
    end
    chk({tag, "_latency"}, first, LAT);
    chk({tag, "_count"}, valid_seen - v0, 1);
    chk({tag, "_word"}, w_c, pl);
    chk({tag, "_is_cmd"}, c_c, pre == 2'b01);
    chk({tag, "_parity_err"}, pe_c, par != ref_par(pl));
    chk({tag, "_preamble_err"}, pre_c, pre == 2'b00);
  endtask

  logic [1:0]  r_pre;
  logic [15:0] r_pl;
  logic [1:0]  r_par;
  int v_snap, e_snap, r_snap;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_word", word, 16'h0000);
    chk("rst_flags", {valid, is_cmd, par_err, pre_err, hexit, hrestart, active}, 7'b0);
    rst = 1'b0;
    hdr_en = 1'b1;
    @(negedge clk);
    chk("active_rise", active, 1'b1);

    send_frame("cmd_8a5a", 2'b01, 16'h8A5A, 2'b11);
    send_frame("par_bad", 2'b01, 16'h8A5A, 2'b10);
    send_frame("data_00ff", 2'b10, 16'h00FF, ref_par(16'h00FF));
    send_frame("pre_00", 2'b00, 16'h1234, ref_par(16'h1234));

    for (int n = 0; n < 8; n++) begin
      r_pre = 2'($urandom_range(0, 3));
      r_pl  = 16'($urandom);
      r_par = ref_par(r_pl);
      if ($urandom_range(0, 2) == 0) r_par = r_par ^ 2'($urandom_range(1, 3));
      send_frame("rand", r_pre, r_pl, r_par);
    end

    // Exit after a partial frame
    v_snap = valid_seen; e_snap = exit_seen;
    drive_bits({2'b01, 16'h8A5A, 2'b11}, 8);
    sda_falls(4);
    repeat (8) @(negedge clk);
    chk("exit_pulse", exit_seen - e_snap, 1);
    chk("exit_no_valid", valid_seen - v_snap, 0);
    chk("exit_inactive", active, 1'b0);
    drive_bits({2'b01, 16'h8A5A, 2'b11}, 20);
    repeat (10) @(negedge clk);
    chk("wait_dis_ignored", valid_seen - v_snap, 0);
    sda = 1'b1;
    hdr_en = 1'b0;
    repeat (3) @(negedge clk);
    hdr_en = 1'b1;
    repeat (3) @(negedge clk);
    send_frame("after_exit", 2'b01, 16'h8A5A, 2'b11);

    // Reset mid-frame
    drive_bits({2'b10, 16'hC3A5, 2'b00}, 12);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_word", word, 16'h0000);
    chk("midrst_flags", {valid, is_cmd, par_err, pre_err, hexit, hrestart, active}, 7'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_frame("after_rst", 2'b11, 16'h5A3C, ref_par(16'h5A3C));

    // Restart after a partial frame
    v_snap = valid_seen; r_snap = restart_seen; e_snap = exit_seen;
    drive_bits({2'b10, 16'hFFFF, 2'b01}, 10);
    sda_falls(2);
    repeat (3) @(negedge clk);
    scl = 1'b1;
    repeat (10) @(negedge clk);
    chk("restart_pulse", restart_seen - r_snap, 1);
    chk("restart_no_valid", valid_seen - v_snap, 0);
    chk("restart_no_exit", exit_seen - e_snap, 0);
    chk("restart_active", active, 1'b1);
    send_frame("after_restart", 2'b01, 16'h8A5A, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    fails++;
    $display("FAIL timeout: run did not complete, observed no finish required finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
